// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types, widths and channel-map helper for the ADC scan sequencer
package adc_pkg;

   localparam int ADC_CH_WIDTH   = 5;
   localparam int ADC_DATA_WIDTH = 12;
   localparam int MAP_MAX_BITS   = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT_RSP,
      ST_EMIT
   } adc_state_t;

   // Entry idx of a packed map made of width-bit fields, zero-extended to 32 bits.
   function automatic logic [31:0] map_entry(input logic [MAP_MAX_BITS-1:0] map,
                                             input int unsigned idx,
                                             input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return 32'(map >> (idx * width)) & mask;
   endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// rtl/adc_avg_accum.sv - per-slot sample accumulator, sample counter and averaged shift-out
module adc_avg_accum
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = ADC_DATA_WIDTH,
   parameter int AVG_LOG2   = 2,
   localparam int CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic [CNT_W-1:0]      sample_cnt,
   output logic                  last_sample,
   output logic [DATA_WIDTH-1:0] avg_data
);

   localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;

   // The average includes the sample arriving this cycle, so the top can latch it on the last one.
   assign acc_sum     = acc + ACC_W'(sample_data);
   assign last_sample = (sample_cnt == LAST_CNT);
   assign avg_data    = DATA_WIDTH'(acc_sum >> AVG_LOG2);

   // Accumulate until the last sample of the slot, then restart clean for the next slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         sample_cnt <= '0;
      end else if (sample_valid) begin
         if (last_sample) begin
            acc        <= '0;
            sample_cnt <= '0;
         end else begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - scan FSM and command driver feeding the ADC core, with averaged per-slot results
module adc_scan_sequencer
   import adc_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CH_WIDTH   = ADC_CH_WIDTH,
   parameter int DATA_WIDTH = ADC_DATA_WIDTH,
   parameter int AVG_LOG2   = 2,
   parameter logic [NUM_CH*CH_WIDTH-1:0] CH_MAP = 20'h0C20,
   localparam int SLOT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1
) (
   input  logic                  clock_clk,
   input  logic                  reset_sink_reset_n,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  err_clear,
   output logic                  command_valid,
   output logic [CH_WIDTH-1:0]   command_channel,
   output logic                  command_startofpacket,
   output logic                  command_endofpacket,
   input  logic                  command_ready,
   input  logic                  response_valid,
   input  logic [CH_WIDTH-1:0]   response_channel,
   input  logic [DATA_WIDTH-1:0] response_data,
   output logic                  result_valid,
   output logic [SLOT_W-1:0]     result_slot,
   output logic [DATA_WIDTH-1:0] result_data,
   output logic                  scan_done,
   output logic                  busy,
   output logic                  err_sticky
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [MAP_MAX_BITS-1:0] MAP_EXT = MAP_MAX_BITS'(CH_MAP);
   // With one slot and no averaging, the opening command is also the closing one.
   localparam logic FIRST_IS_EOP = (NUM_CH == 1) && (AVG_LOG2 == 0);

   adc_state_t            state;
   logic [SLOT_W-1:0]     slot;
   logic [SLOT_W-1:0]     next_slot;
   logic [CNT_W-1:0]      sample_cnt;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  last_sample;
   logic [DATA_WIDTH-1:0] avg_data;
   logic                  accept;
   logic                  err_set;

   function automatic logic [CH_WIDTH-1:0] slot_channel(input logic [SLOT_W-1:0] s);
      return CH_WIDTH'(map_entry(MAP_EXT, 32'(s), CH_WIDTH));
   endfunction

   assign next_slot = slot + SLOT_W'(1);
   assign cnt_inc   = sample_cnt + CNT_W'(1);
   assign accept    = (state == ST_WAIT_RSP) && response_valid;
   // Unsolicited samples and samples from the wrong channel are both flagged.
   assign err_set   = response_valid &&
                      ((state != ST_WAIT_RSP) || (response_channel != slot_channel(slot)));

   adc_avg_accum #(
      .DATA_WIDTH (DATA_WIDTH),
      .AVG_LOG2   (AVG_LOG2)
   ) u_avg (
      .clk          (clock_clk),
      .rst_n        (reset_sink_reset_n),
      .sample_valid (accept),
      .sample_data  (response_data),
      .sample_cnt   (sample_cnt),
      .last_sample  (last_sample),
      .avg_data     (avg_data)
   );

   // Scan FSM; command fields are loaded for the slot/count the next command will carry.
   always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         state                 <= ST_IDLE;
         slot                  <= '0;
         command_valid         <= 1'b0;
         command_channel       <= '0;
         command_startofpacket <= 1'b0;
         command_endofpacket   <= 1'b0;
         result_valid          <= 1'b0;
         result_slot           <= '0;
         result_data           <= '0;
         scan_done             <= 1'b0;
         busy                  <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         scan_done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start || continuous) begin
                  state                 <= ST_CMD;
                  busy                  <= 1'b1;
                  slot                  <= '0;
                  command_valid         <= 1'b1;
                  command_channel       <= slot_channel('0);
                  command_startofpacket <= 1'b1;
                  command_endofpacket   <= FIRST_IS_EOP;
               end
            end
            ST_CMD: begin
               if (command_ready) begin
                  state                 <= ST_WAIT_RSP;
                  command_valid         <= 1'b0;
                  command_startofpacket <= 1'b0;
                  command_endofpacket   <= 1'b0;
               end
            end
            ST_WAIT_RSP: begin
               if (response_valid) begin
                  if (!last_sample) begin
                     state                 <= ST_CMD;
                     command_valid         <= 1'b1;
                     command_channel       <= slot_channel(slot);
                     command_startofpacket <= 1'b0;
                     command_endofpacket   <= (slot == LAST_SLOT) && (cnt_inc == LAST_CNT);
                  end else begin
                     state        <= ST_EMIT;
                     result_valid <= 1'b1;
                     result_slot  <= slot;
                     result_data  <= avg_data;
                     scan_done    <= (slot == LAST_SLOT);
                  end
               end
            end
            ST_EMIT: begin
               if (slot != LAST_SLOT) begin
                  state                 <= ST_CMD;
                  slot                  <= next_slot;
                  command_valid         <= 1'b1;
                  command_channel       <= slot_channel(next_slot);
                  command_startofpacket <= 1'b0;
                  command_endofpacket   <= (next_slot == LAST_SLOT) && (AVG_LOG2 == 0);
               end else if (continuous) begin
                  state                 <= ST_CMD;
                  slot                  <= '0;
                  command_valid         <= 1'b1;
                  command_channel       <= slot_channel('0);
                  command_startofpacket <= 1'b1;
                  command_endofpacket   <= FIRST_IS_EOP;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flag; a new error outranks a clear arriving in the same cycle.
   always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
      if (!reset_sink_reset_n) begin
         err_sticky <= 1'b0;
      end else if (err_set) begin
         err_sticky <= 1'b1;
      end else if (err_clear) begin
         err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // dut_a: 3 slots mapped to channels 0,1,3, no averaging
   logic        a_start, a_cont, a_err_clear, a_cmd_ready;
   logic        a_rsp_valid;
   logic [4:0]  a_rsp_ch;
   logic [11:0] a_rsp_data;
   logic        a_cmd_valid, a_sop, a_eop;
   logic [4:0]  a_cmd_ch;
   logic        a_res_valid, a_scan_done, a_busy, a_err;
   logic [1:0]  a_res_slot;
   logic [11:0] a_res_data;
   logic [25:0] a_outs;

   // dut_b: 2 slots mapped to channels 0,1, four samples averaged
   logic        b_start, b_cmd_ready, b_rsp_valid;
   logic [4:0]  b_rsp_ch;
   logic [11:0] b_rsp_data;
   logic        b_cmd_valid, b_sop, b_eop;
   logic [4:0]  b_cmd_ch;
   logic        b_res_valid, b_scan_done, b_busy, b_err;
   logic [0:0]  b_res_slot;
   logic [11:0] b_res_data;
   logic        b_zero = 1'b0;

   assign a_outs = {a_cmd_valid, a_cmd_ch, a_sop, a_eop, a_res_valid, a_res_slot,
                    a_res_data, a_scan_done, a_busy, a_err};

   adc_scan_sequencer #(.NUM_CH(3), .CH_WIDTH(5), .DATA_WIDTH(12), .AVG_LOG2(0), .CH_MAP(15'h0C20)) dut_a (
      .clock_clk(clk), .reset_sink_reset_n(rst_n), .start(a_start), .continuous(a_cont),
      .err_clear(a_err_clear), .command_valid(a_cmd_valid), .command_channel(a_cmd_ch),
      .command_startofpacket(a_sop), .command_endofpacket(a_eop), .command_ready(a_cmd_ready),
      .response_valid(a_rsp_valid), .response_channel(a_rsp_ch), .response_data(a_rsp_data),
      .result_valid(a_res_valid), .result_slot(a_res_slot), .result_data(a_res_data),
      .scan_done(a_scan_done), .busy(a_busy), .err_sticky(a_err));

   adc_scan_sequencer #(.NUM_CH(2), .CH_WIDTH(5), .DATA_WIDTH(12), .AVG_LOG2(2), .CH_MAP(10'h020)) dut_b (
      .clock_clk(clk), .reset_sink_reset_n(rst_n), .start(b_start), .continuous(b_zero),
      .err_clear(b_zero), .command_valid(b_cmd_valid), .command_channel(b_cmd_ch),
      .command_startofpacket(b_sop), .command_endofpacket(b_eop), .command_ready(b_cmd_ready),
      .response_valid(b_rsp_valid), .response_channel(b_rsp_ch), .response_data(b_rsp_data),
      .result_valid(b_res_valid), .result_slot(b_res_slot), .result_data(b_res_data),
      .scan_done(b_scan_done), .busy(b_busy), .err_sticky(b_err));

   // dut_a monitor and responder state
   int a_cmd_q[$];
   int a_sop_q[$];
   int a_eop_q[$];
   int a_cmd_cyc_q[$];
   int a_res_slot_q[$];
   int a_res_data_q[$];
   int a_res_cyc_q[$];
   int a_rsp_cyc_q[$];
   int a_done_slot_q[$];
   int a_done_cnt = 0;
   bit a_auto, a_bad, a_inject;
   bit a_pend = 1'b0;
   logic [4:0] a_pend_ch = '0;

   // dut_b monitor and responder state
   logic [11:0] b_data [8] = '{12'd100, 12'd101, 12'd102, 12'd103, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
   int b_idx = 0;
   int b_cmd_n = 0;
   int b_sop_at[$];
   int b_eop_at[$];
   int b_res_slot_q[$];
   int b_res_data_q[$];
   int b_done_slot_q[$];
   bit b_pend = 1'b0;
   logic [4:0] b_pend_ch = '0;

   function automatic logic [11:0] a_data_for(input logic [4:0] ch);
      case (ch)
         5'd0:    return 12'h100;
         5'd1:    return 12'h200;
         5'd3:    return 12'h300;
         default: return 12'hFFF;
      endcase
   endfunction

   // dut_a: record traffic, then answer each accepted command on the following negedge
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_cmd_valid && a_cmd_ready) begin
            a_cmd_q.push_back(int'(a_cmd_ch));
            a_sop_q.push_back(int'(a_sop));
            a_eop_q.push_back(int'(a_eop));
            a_cmd_cyc_q.push_back(cyc);
         end
         if (a_res_valid) begin
            a_res_slot_q.push_back(int'(a_res_slot));
            a_res_data_q.push_back(int'(a_res_data));
            a_res_cyc_q.push_back(cyc);
         end
         if (a_scan_done) begin
            a_done_cnt++;
            a_done_slot_q.push_back(int'(a_res_slot));
         end
      end
      a_rsp_valid = 1'b0;
      if (a_inject) begin
         a_rsp_valid = 1'b1;
         a_rsp_ch    = 5'd0;
         a_rsp_data  = 12'h055;
      end else if (a_auto && a_pend) begin
         a_rsp_valid = 1'b1;
         a_rsp_ch    = (a_bad && a_pend_ch == 5'd1) ? 5'd7 : a_pend_ch;
         a_rsp_data  = a_data_for(a_pend_ch);
         a_rsp_cyc_q.push_back(cyc);
      end
      a_pend = 1'b0;
      if (a_auto && rst_n && a_cmd_valid && a_cmd_ready) begin
         a_pend    = 1'b1;
         a_pend_ch = a_cmd_ch;
      end
   end

   // dut_b: record traffic and echo each command back with the next table sample
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_cmd_valid && b_cmd_ready) begin
            if (b_sop) b_sop_at.push_back(b_cmd_n);
            if (b_eop) b_eop_at.push_back(b_cmd_n);
            b_cmd_n++;
         end
         if (b_res_valid) begin
            b_res_slot_q.push_back(int'(b_res_slot));
            b_res_data_q.push_back(int'(b_res_data));
         end
         if (b_scan_done) b_done_slot_q.push_back(int'(b_res_slot));
      end
      b_rsp_valid = 1'b0;
      if (b_pend) begin
         b_rsp_valid = 1'b1;
         b_rsp_ch    = b_pend_ch;
         b_rsp_data  = b_data[b_idx & 7];
         b_idx++;
      end
      b_pend = 1'b0;
      if (rst_n && b_cmd_valid && b_cmd_ready) begin
         b_pend    = 1'b1;
         b_pend_ch = b_cmd_ch;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_a_start();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic wait_a_done(input int target);
      int n = 0;
      while ((a_done_cnt < target || a_busy) && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) check("a_wait_timeout", 32'(a_done_cnt) | (32'(a_busy) << 31), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int qc, qr, qd, n, nsop, neop;
      int exp_ch [3]   = '{0, 1, 3};
      int exp_data [3] = '{'h100, 'h200, 'h300};

      rst_n = 1'b0;
      a_start = 1'b0; a_cont = 1'b0; a_err_clear = 1'b0; a_cmd_ready = 1'b1;
      a_auto = 1'b1; a_bad = 1'b0; a_inject = 1'b0;
      b_start = 1'b0; b_cmd_ready = 1'b1;
      repeat (3) tick();
      check("reset_a_outputs", 32'(a_outs), 32'd0);
      check("reset_b_busy", 32'(b_busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // averaging: 100..103 -> 101, 4095 x4 -> 4095
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      n = 0;
      while ((b_done_slot_q.size() < 1 || b_busy) && n < 200) begin tick(); n++; end
      check("avg_result_count", 32'(b_res_data_q.size()), 32'd2);
      check("avg_slot0_data", 32'(b_res_data_q[0]), 32'd101);
      check("avg_slot1_data", 32'(b_res_data_q[1]), 32'd4095);
      check("avg_slot1_idx", 32'(b_res_slot_q[1]), 32'd1);
      check("avg_done_slot", 32'(b_done_slot_q[0]), 32'd1);
      check("avg_cmd_count", 32'(b_cmd_n), 32'd8);
      check("avg_sop_pos", 32'(b_sop_at.size() * 16 + b_sop_at[0]), 32'd16);
      check("avg_eop_pos", 32'(b_eop_at.size() * 16 + b_eop_at[0]), 32'd23);
      check("avg_err", 32'(b_err), 32'd0);

      // single scan, channels 0,1,3
      qc = a_cmd_q.size(); qr = a_res_slot_q.size(); qd = a_done_cnt;
      pulse_a_start();
      wait_a_done(qd + 1);
      check("t1_cmd_count", 32'(a_cmd_q.size() - qc), 32'd3);
      check("t1_res_count", 32'(a_res_slot_q.size() - qr), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t1_cmd_ch%0d", i), 32'(a_cmd_q[qc+i]), 32'(exp_ch[i]));
         check($sformatf("t1_sop%0d", i), 32'(a_sop_q[qc+i]), 32'(i == 0));
         check($sformatf("t1_eop%0d", i), 32'(a_eop_q[qc+i]), 32'(i == 2));
         check($sformatf("t1_res_slot%0d", i), 32'(a_res_slot_q[qr+i]), 32'(i));
         check($sformatf("t1_res_data%0d", i), 32'(a_res_data_q[qr+i]), 32'(exp_data[i]));
      end
      check("t1_rsp_to_result", 32'(a_res_cyc_q[qr] - a_rsp_cyc_q[qr]), 32'd1);
      check("t1_emit_to_cmd", 32'(a_cmd_cyc_q[qc+1] - a_res_cyc_q[qr]), 32'd1);
      check("t1_done_slot", 32'(a_done_slot_q[qd]), 32'd2);
      check("t1_busy_after", 32'(a_busy), 32'd0);
      check("t1_result_held", 32'(a_res_data), 32'h300);

      // backpressure: command_ready low for 5 cycles
      qc = a_cmd_q.size(); qr = a_res_slot_q.size(); qd = a_done_cnt;
      a_cmd_ready = 1'b0;
      pulse_a_start();
      for (int i = 0; i < 5; i++) begin
         check("t3_valid_hold", 32'(a_cmd_valid), 32'd1);
         check("t3_ch_hold", 32'(a_cmd_ch), 32'd0);
         check("t3_sop_hold", 32'(a_sop), 32'd1);
         tick();
      end
      a_cmd_ready = 1'b1;
      wait_a_done(qd + 1);
      check("t3_cmd_count", 32'(a_cmd_q.size() - qc), 32'd3);
      check("t3_first_ch", 32'(a_cmd_q[qc]), 32'd0);
      check("t3_res_count", 32'(a_res_slot_q.size() - qr), 32'd3);

      // continuous: drop the level during the third scan
      qc = a_cmd_q.size(); qr = a_res_slot_q.size(); qd = a_done_cnt;
      a_cont = 1'b1;
      n = 0;
      while (a_res_slot_q.size() < qr + 7 && n < 400) begin tick(); n++; end
      a_cont = 1'b0;
      wait_a_done(qd + 3);
      repeat (10) tick();
      check("t4_scan_count", 32'(a_done_cnt - qd), 32'd3);
      check("t4_res_count", 32'(a_res_slot_q.size() - qr), 32'd9);
      for (int i = 0; i < 9; i++)
         check($sformatf("t4_slot%0d", i), 32'(a_res_slot_q[qr+i]), 32'(i % 3));
      nsop = 0; neop = 0;
      for (int i = qc; i < a_cmd_q.size(); i++) begin
         nsop += a_sop_q[i];
         neop += a_eop_q[i];
      end
      check("t4_sop_count", 32'(nsop), 32'd3);
      check("t4_eop_count", 32'(neop), 32'd3);
      check("t4_busy_after", 32'(a_busy), 32'd0);

      // errors: wrong channel on slot 1, then an unsolicited response while idle
      qr = a_res_slot_q.size(); qd = a_done_cnt;
      a_bad = 1'b1;
      pulse_a_start();
      wait_a_done(qd + 1);
      a_bad = 1'b0;
      check("t5_err_bad_ch", 32'(a_err), 32'd1);
      check("t5_res_count", 32'(a_res_slot_q.size() - qr), 32'd3);
      check("t5_slot1_data", 32'(a_res_data_q[qr+1]), 32'h200);
      a_err_clear = 1'b1;
      tick();
      a_err_clear = 1'b0;
      check("t5_err_cleared", 32'(a_err), 32'd0);
      qr = a_res_slot_q.size();
      a_inject = 1'b1;
      tick();
      a_inject = 1'b0;
      tick();
      check("t5_err_unsolicited", 32'(a_err), 32'd1);
      repeat (3) tick();
      check("t5_no_result", 32'(a_res_slot_q.size() - qr), 32'd0);
      check("t5_idle_busy", 32'(a_busy), 32'd0);
      a_inject = 1'b1;
      a_err_clear = 1'b1;
      tick();
      a_inject = 1'b0;
      a_err_clear = 1'b0;
      tick();
      check("t5_set_beats_clear", 32'(a_err), 32'd1);
      a_err_clear = 1'b1;
      tick();
      a_err_clear = 1'b0;
      check("t5_err_cleared2", 32'(a_err), 32'd0);

      // reset while waiting for the slot-1 response
      qc = a_cmd_q.size();
      pulse_a_start();
      n = 0;
      while (a_cmd_q.size() < qc + 2 && n < 100) begin tick(); n++; end
      check("t6_busy_before", 32'(a_busy), 32'd1);
      qr = a_res_slot_q.size();
      rst_n = 1'b0;
      a_auto = 1'b0;
      #1;
      check("t6_reset_outputs", 32'(a_outs), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      a_auto = 1'b1;
      tick();
      check("t6_no_stray_result", 32'(a_res_slot_q.size() - qr), 32'd0);
      qc = a_cmd_q.size(); qr = a_res_slot_q.size(); qd = a_done_cnt;
      pulse_a_start();
      wait_a_done(qd + 1);
      check("t6_first_ch", 32'(a_cmd_q[qc]), 32'd0);
      check("t6_first_sop", 32'(a_sop_q[qc]), 32'd1);
      check("t6_res_count", 32'(a_res_slot_q.size() - qr), 32'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("t6_slot%0d", i), 32'(a_res_slot_q[qr+i]), 32'(i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
